// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver with frame snapshots and
// leading-zero blanking; outputs are registered and active-low.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bcd_digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_in,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned PW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(REFRESH_DIV - 1);

  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic        lz;
  } snap_t;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  snap_t         snap;
  logic          load_pending;

  logic          tick;
  logic          load;
  logic [7:0]    lz_zero;
  logic [3:0]    nib;
  logic          shown;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  assign tick = (presc == TOP);
  assign load = (tick && idx == 3'd7) || load_pending;

  // lz_zero[i]: nibbles i..7 of the snapshot are all zero
  always_comb begin
    lz_zero = '0;
    lz_zero[7] = (snap.bcd[31:28] == 4'd0);
    for (int i = 6; i >= 0; i--) begin
      lz_zero[i] = lz_zero[i+1] && (snap.bcd[i*4 +: 4] == 4'd0);
    end
  end

  always_comb begin
    nib     = snap.bcd[idx*4 +: 4];
    shown   = snap.en[idx] &&
              !(snap.lz && idx != 3'd0 && lz_zero[idx]);
    an_nxt  = 8'hFF;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    if (shown) begin
      an_nxt  = ~(8'd1 << idx);
      seg_nxt = decode(nib);
      dp_nxt  = ~snap.dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc        <= '0;
      idx          <= '0;
      snap         <= '0;
      load_pending <= 1'b1;
      an           <= 8'hFF;
      seg          <= 7'h7F;
      dp           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + 1'b1;
      idx        <= tick ? idx + 3'd1 : idx;
      frame_done <= load;
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      if (load) begin
        snap.bcd     <= bcd_digits;
        snap.en      <= digit_en;
        snap.dp      <= dp_in;
        snap.lz      <= blank_lz;
        load_pending <= 1'b0;
      end
    end
  end

endmodule
